fft_bitrev_loader: RTL and testbench
====================================

FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 Parameter N_POINTS, default 8: frame length; SHALL be a power of two, at least 4.
REQ-002 Parameter SAMPLE_SIZE, default 32: sample and butterfly operand width, signed.
REQ-003 Parameter TWIDDLE_SIZE, default 16: twiddle width, signed.
REQ-004 Parameter NO_FLOAT_MULT, default 1000: fixed-point scale of twiddle value 1.0.
REQ-005 Ports SHALL be as follows, with clock and reset listed first.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_sample  in  SAMPLE_SIZE  signed real audio sample.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  block accepts in_sample this cycle.
- even_real, even_imag  out  SAMPLE_SIZE  even butterfly operand.
- odd_real, odd_imag  out  SAMPLE_SIZE  odd butterfly operand.
- twiddle_real, twiddle_imag  out  TWIDDLE_SIZE  stage-1 twiddle.
- pair_index  out  log2(N_POINTS)-1  index k of the presented pair, 0..N_POINTS/2-1.
- out_valid  out  1  the operand pair is valid.
- out_ready  in  1  the downstream butterfly consumes the pair.
- frame_done  out  1  one-cycle pulse after the last pair is consumed.

Function
REQ-006 The block SHALL contain a storage array of N_POINTS entries, a write counter, a pair counter and a two-state FSM with states FILL and DRAIN.
REQ-007 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-008 An input sample is accepted only when in_valid and in_ready are both 1.
- Sample number w (0-based within the frame) SHALL be written to entry bitrev(w).
- bitrev reverses the log2(N_POINTS) address bits.
REQ-009 Acceptance of sample N_POINTS-1 SHALL move the FSM to DRAIN on the same edge, clear the write counter and clear the pair counter.
REQ-010 In DRAIN, in_ready SHALL be 0; in_valid SHALL be ignored and no storage write occurs.
REQ-011 In DRAIN, out_valid SHALL be 1 and the operands SHALL be driven as follows.
- even_real = entry[2k] and odd_real = entry[2k+1], where k = pair_index.
- even_imag = 0 and odd_imag = 0.
- Latency: the first pair is valid in the cycle after the last sample is accepted.
REQ-012 twiddle_real SHALL equal NO_FLOAT_MULT and twiddle_imag SHALL equal 0 in all states.
- This value is W2^0, the only stage-1 radix-2 twiddle.
REQ-013 While out_valid is 1 and out_ready is 0, all operand outputs and pair_index SHALL hold stable.
REQ-014 A pair is consumed when out_valid and out_ready are both 1; pair_index SHALL then increment.
REQ-015 Consumption of pair N_POINTS/2-1 SHALL trigger the end-of-frame sequence.
- On the same edge: FSM returns to FILL, pair counter clears, frame_done is set.
- frame_done SHALL be 1 for exactly the following cycle only.
REQ-016 When out_ready is held high, the block SHALL sustain one pair per cycle; a full frame takes N_POINTS fill cycles plus N_POINTS/2 drain cycles.
REQ-017 Storage contents SHALL NOT be cleared between frames; each new frame overwrites every entry before DRAIN.
REQ-018 The block SHALL perform no arithmetic on samples; values pass bit-exact and signed.

Reset
REQ-019 While rst_n is 0, regardless of clk, the block SHALL hold the following values.
- FSM = FILL; write counter = 0; pair counter = 0.
- in_ready = 1; out_valid = 0; frame_done = 0; pair_index = 0.
- Storage contents need not be cleared.
REQ-020 A reset asserted mid-FILL or mid-DRAIN SHALL discard the partial frame.
- After rst_n returns to 1, the next accepted sample is sample 0 of a new frame.
REQ-021 In the first cycle after reset release, the block SHALL accept input if in_valid is 1.

Verification
REQ-022 N_POINTS=8, samples 10,11,...,17 fed back-to-back, out_ready=1 -> pairs in order: (10,14), (12,16), (11,15), (13,17).
- pair_index runs 0..3, imag outputs 0, twiddle = (1000,0).
- frame_done is high in the cycle after pair 3.
REQ-023 Signed samples -5, 7, -32768, 0, 1, -1, 3, -3 -> pairs (-5,1), (-32768,3), (7,-1), (0,-3), bit-exact at SAMPLE_SIZE=32.
REQ-024 out_ready low for 3 cycles while pair 1 is presented -> outputs and pair_index stay constant; the sequence resumes without loss or duplication.
REQ-025 in_valid kept high throughout DRAIN -> in_ready=0 and storage is unchanged; the next frame starts only after frame_done.
- The 9th driven value becomes sample 0 of frame 2.
REQ-026 rst_n pulsed low after 5 accepted samples -> reset values appear immediately, without waiting for a clk edge.
- A fresh 8-sample frame then produces correct pairs unaffected by the discarded samples.
REQ-027 Two consecutive frames with in_valid and out_ready held at 1 -> 12 cycles per frame and correct pairs for both frames.

Source files
------------

// File: rtl/fft_bitrev_loader.sv
// Collects one frame of real samples in bit-reversed order, then streams the
// stage-1 radix-2 butterfly operand pairs (entry 2k, entry 2k+1) downstream.
module fft_bitrev_loader #(
   parameter int N_POINTS      = 8,
   parameter int SAMPLE_SIZE   = 32,
   parameter int TWIDDLE_SIZE  = 16,
   parameter int NO_FLOAT_MULT = 1000,
   localparam int ADDR_W       = $clog2(N_POINTS),
   localparam int PAIR_W       = ADDR_W - 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic signed [SAMPLE_SIZE-1:0]  in_sample,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic signed [SAMPLE_SIZE-1:0]  even_real,
   output logic signed [SAMPLE_SIZE-1:0]  even_imag,
   output logic signed [SAMPLE_SIZE-1:0]  odd_real,
   output logic signed [SAMPLE_SIZE-1:0]  odd_imag,
   output logic signed [TWIDDLE_SIZE-1:0] twiddle_real,
   output logic signed [TWIDDLE_SIZE-1:0] twiddle_imag,
   output logic        [PAIR_W-1:0]       pair_index,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           frame_done
);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        wr_cnt_q, wr_cnt_d;
   logic [PAIR_W-1:0]        pair_cnt_q, pair_cnt_d;
   logic                     frame_done_q, frame_done_d;
   logic signed [SAMPLE_SIZE-1:0] mem_q [N_POINTS];

   logic wr_en, rd_en, last_wr, last_pair;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
      return r;
   endfunction

   assign wr_en     = in_valid && in_ready;
   assign rd_en     = out_valid && out_ready;
   assign last_wr   = wr_en && (wr_cnt_q == ADDR_W'(N_POINTS - 1));
   assign last_pair = rd_en && (pair_cnt_q == PAIR_W'(N_POINTS / 2 - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         wr_cnt_q     <= '0;
         pair_cnt_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         pair_cnt_q   <= pair_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      pair_cnt_d   = pair_cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         FILL: begin
            if (last_wr) begin
               state_d    = DRAIN;
               wr_cnt_d   = '0;
               pair_cnt_d = '0;
            end else if (wr_en) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (last_pair) begin
               state_d      = FILL;
               pair_cnt_d   = '0;
               frame_done_d = 1'b1;
            end else if (rd_en) begin
               pair_cnt_d = pair_cnt_q + 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == FILL);
      out_valid = (state_q == DRAIN);
   end

   // Storage is never written in DRAIN, so the read pair holds while stalled.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[bitrev(wr_cnt_q)] <= in_sample;
   end

   assign even_real    = mem_q[{pair_cnt_q, 1'b0}];
   assign odd_real     = mem_q[{pair_cnt_q, 1'b1}];
   assign even_imag    = '0;
   assign odd_imag     = '0;
   assign twiddle_real = TWIDDLE_SIZE'(NO_FLOAT_MULT);
   assign twiddle_imag = '0;
   assign pair_index   = pair_cnt_q;
   assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Scoreboard bench for fft_bitrev_loader: directed frames push expected pairs,
// a negedge monitor pops and compares whenever a pair is presented.
module tb_fft_bitrev_loader;

   localparam int N = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [31:0] in_sample = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [31:0] even_real, even_imag, odd_real, odd_imag;
   logic signed [15:0] twiddle_real, twiddle_imag;
   logic [1:0]         pair_index;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               frame_done;

   fft_bitrev_loader #(.N_POINTS(N), .SAMPLE_SIZE(32), .TWIDDLE_SIZE(16), .NO_FLOAT_MULT(1000)) dut (
      .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
      .even_real(even_real), .even_imag(even_imag), .odd_real(odd_real), .odd_imag(odd_imag),
      .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag), .pair_index(pair_index),
      .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct { longint ev; longint od; int idx; } pair_t;
   pair_t sb[$];

   // Hand-computed frames: samples in arrival order and the expected pairs.
   longint va[8] = '{10, 11, 12, 13, 14, 15, 16, 17};
   longint ea[4] = '{10, 12, 11, 13};
   longint oa[4] = '{14, 16, 15, 17};
   longint vb[8] = '{-5, 7, -32768, 0, 1, -1, 3, -3};
   longint eb[4] = '{-5, -32768, 7, 0};
   longint ob[4] = '{1, 3, -1, -3};
   longint vc[8] = '{100, 101, 102, 103, 104, 105, 106, 107};
   longint ec[4] = '{100, 102, 101, 103};
   longint oc[4] = '{104, 106, 105, 107};
   longint ve[8] = '{300, 301, 302, 303, 304, 305, 306, 307};
   longint ee[4] = '{300, 302, 301, 303};
   longint oe[4] = '{304, 306, 305, 307};
   longint vd[8] = '{-200, 201, -202, 203, -204, 205, -206, 207};
   longint ed[4] = '{-200, -202, 201, 203};
   longint od_[4] = '{-204, -206, 205, 207};

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic feed_sample(input longint v, output int stalls);
      in_sample = 32'(v);
      in_valid  = 1'b1;
      stalls    = 0;
      @(negedge clk);
      while (!in_ready && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      chk("in_ready_at_accept", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic feed_frame(input longint v[8], input longint ev[4], input longint od[4],
                             output int t0, output int st0);
      int st;
      for (int k = 0; k < 4; k++) sb.push_back('{ev[k], od[k], k});
      t0 = 0;
      st0 = 0;
      for (int i = 0; i < 8; i++) begin
         feed_sample(v[i], st);
         if (i == 0) begin
            st0 = st;
            t0  = cyc;
         end
      end
   endtask

   // Monitor: frame_done expected exactly one cycle after the last pair is consumed.
   logic fd_exp = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            fd_exp = 1'b0;
         end else begin
            chk("frame_done", frame_done, fd_exp);
            fd_exp = 1'b0;
            if (out_valid) begin
               chk("pair_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  chk("even_real", even_real, sb[0].ev);
                  chk("odd_real", odd_real, sb[0].od);
                  chk("pair_index", pair_index, sb[0].idx);
                  chk("even_imag", even_imag, 0);
                  chk("odd_imag", odd_imag, 0);
                  chk("twiddle_real", twiddle_real, 1000);
                  chk("twiddle_imag", twiddle_imag, 0);
                  if (out_ready) begin
                     fd_exp = (sb[0].idx == N / 2 - 1);
                     void'(sb.pop_front());
                  end
               end
            end
         end
      end
   end

   initial begin
      int ta, tb_, tc, st_a, st_b, st_c, st_d, t_d, st;
      // Reset values must be present before any clock edge.
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pair_index", pair_index, 0);
      chk("rst_twiddle_real", twiddle_real, 1000);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // A then B then C back-to-back; each next first sample waits through DRAIN.
      feed_frame(va, ea, oa, ta, st_a);
      chk("first_accept_no_stall", st_a, 0);
      feed_frame(vb, eb, ob, tb_, st_b);
      chk("drain_stall_cycles", st_b, 4);
      chk("frame_period_ab", tb_ - ta, 12);
      feed_frame(vc, ec, oc, tc, st_c);
      chk("frame_period_bc", tc - tb_, 12);
      in_valid = 1'b0;
      // C: pair 0 is presented now; stall 3 cycles on pair 1.
      @(posedge clk);
      #1 out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("queue_drained_c", sb.size(), 0);

      // E: reset asserted mid-DRAIN while pair 1 is held.
      feed_frame(ve, ee, oe, t_d, st);
      in_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_pair_index", pair_index, 1);
      chk("pre_rst_out_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_pair_index", pair_index, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;

      // Partial frame of 5 samples, then reset discards it.
      feed_sample(50, st);
      chk("accept_right_after_reset", st, 0);
      for (int i = 51; i < 55; i++) feed_sample(i, st);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("partial_rst_in_ready", in_ready, 1);
      chk("partial_rst_out_valid", out_valid, 0);
      chk("partial_rst_frame_done", frame_done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      feed_frame(vd, ed, od_, t_d, st_d);
      chk("fresh_frame_no_stall", st_d, 0);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("queue_drained_d", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
